seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DWELL_CYCLES, default 1000, sets the cycles each digit is driven per frame (minimum 1).
REQ-002 Parameter BLANK_CYCLES, default 16, sets the ghost-blanking cycles before each digit (minimum 1).
REQ-003 clk  input  1  single clock; all state SHALL be updated on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  display enable; low forces blank pins.
REQ-006 in_valid  input  1  load request.
REQ-007 in_ready  output  1  high when the pending buffer is empty.
REQ-008 in_data  input  32  eight hex nibbles; nibble k drives digit k, digit 0 rightmost.
REQ-009 in_dp  input  3  decimal-point digit index.
REQ-010 in_dp_en  input  1  decimal point enable.
REQ-011 in_lzs  input  1  leading-zero suppression enable.
REQ-012 seg_o  output  8  shared segment bus, active-low; bit7 = dp, bits6..0 = g..a.
REQ-013 an_o  output  8  digit select, active-low, one-hot-zero.
REQ-014 frame_o  output  1  one-cycle pulse on the last cycle of each frame.

Function
REQ-015 States SHALL be BLANK and SHOW; after reset the block is in BLANK with digit index 0 and dwell counter 0.
REQ-016 BLANK SHALL last exactly BLANK_CYCLES cycles, then go to SHOW; SHOW SHALL last exactly DWELL_CYCLES cycles, then go to BLANK with the index incremented modulo 8.
REQ-017 A frame SHALL be 8*(BLANK_CYCLES+DWELL_CYCLES) cycles; the frame boundary is the last SHOW cycle of digit 7, where frame_o SHALL be 1.
REQ-018 seg_o and an_o SHALL be registered and SHALL reflect the state/index of the same cycle: on the first rising edge after reset release (cycle 0), BLANK output SHALL be shown for cycles 0..BLANK_CYCLES-1.
REQ-019 In BLANK, an_o=8'hFF and seg_o=8'hFF; in SHOW, an_o=~(1<<index) and seg_o = font(nibble) with bit7 cleared when in_dp_en is set and index equals dp.
REQ-020 Font SHALL be standard hex: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=88,b=83,C=C6,d=A1,E=86,F=8E (bit7=1).
REQ-021 With lzs set, each digit above the highest nonzero nibble SHALL show seg_o=8'hFF while its anode remains asserted; digit 0, the dp digit and all digits below it SHALL never be suppressed.
REQ-022 A load SHALL be accepted when in_valid and in_ready are both 1; data, dp, dp_en and lzs are captured into the pending buffer and in_ready drops the next cycle.
REQ-023 At the frame boundary, a full pending buffer SHALL be copied to the active register and cleared; the new value SHALL be shown from the first cycle of the next frame, so no frame mixes old and new digits.
REQ-024 A load accepted on the frame-boundary cycle itself SHALL be applied at the following boundary.
REQ-025 When en=0, an_o and seg_o SHALL be 8'hFF; the state machine, frame_o and pending-to-active transfers SHALL keep running.

Reset
REQ-026 Asserting rst SHALL immediately force an_o=8'hFF, seg_o=8'hFF, frame_o=0 and in_ready=1.
REQ-027 Asserting rst SHALL set state=BLANK, index=0, counter=0, pending empty and active = 0 with dp_en=0 and lzs=0; a reset mid-SHOW discards any pending load.

Structure
REQ-028 Package seg_pkg SHALL hold the state enum, the 16-entry font table and the width constants (digit count 8, nibble width 4).
REQ-029 The nibble-to-segment decoder SHALL be the combinational sub-module seg_font; the remaining logic is flat.

Verification
REQ-030 Use DWELL=4 and BLANK=2, with reset released. Required: cycles 0-1 show an=FF/seg=FF; cycles 2-5 show an=FE/seg=C0; frame_o=1 only on cycle 47 and then every 48 cycles.
REQ-031 Load 32'h00000016 with dp=1, dp_en=1, lzs=1 mid-frame. Required from the next frame: digit0 seg=82, digit1 seg=79, digits 2-7 seg=FF with anodes asserted.
REQ-032 Issue back-to-back loads 32'h1 then 32'h2 mid-frame. Required: first accepted and in_ready=0 until boundary, second held off; second shown one frame after the first.
REQ-033 Load 32'hF on the boundary cycle. Required: current next frame still shows old value, following frame shows digit0 seg=8E.
REQ-034 Drive en=0 for one frame. Required: pins stay FF and frame_o still pulses.
REQ-035 Assert rst mid-SHOW with a pending load. Required: pins go FF in the same cycle; after release the display shows 00000000 (C0 on each digit).

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 8-digit seven-segment scanner.
// Holds the scan state enum, the hex font and the display configuration record.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int NIBBLE_W   = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int DATA_W     = NUM_DIGITS * NIBBLE_W;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Active-low segments, bit7 = dp (off), bits6..0 = g..a
  localparam logic [7:0] FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  dp;
    logic              dp_en;
    logic              lzs;
  } disp_cfg_t;

  function automatic logic [IDX_W-1:0] highestNonzero(input logic [DATA_W-1:0] d);
    logic [IDX_W-1:0] h;
    h = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (d[k*NIBBLE_W +: NIBBLE_W] != '0) h = IDX_W'(k);
    end
    return h;
  endfunction

endpackage

// File: rtl/seg_font.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module seg_font
  import seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_nibble,
  output logic [7:0]          o_seg
);

  assign o_seg = FONT[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit display scanner with ghost blanking, a one-deep
// load buffer swapped only at frame boundaries, dp insertion and zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_dp,
  input  logic              in_dp_en,
  input  logic              in_lzs,
  output logic [7:0]        seg_o,
  output logic [7:0]        an_o,
  output logic              frame_o
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e       r_state;
  scan_state_e       w_stateNext;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idxNext;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cntNext;
  logic [7:0]        r_an;
  logic [7:0]        r_seg;
  logic [7:0]        w_anNext;
  logic [7:0]        w_segNext;
  disp_cfg_t         r_pend;
  disp_cfg_t         r_act;
  logic              r_pendFull;
  logic              w_frame;
  logic              w_load;
  logic [NIBBLE_W-1:0] w_nibble;
  logic [7:0]        w_fontSeg;
  logic [IDX_W-1:0]  w_highNz;
  logic              w_suppress;

  assign w_frame  = (r_state == ST_SHOW) && (r_idx == LAST_IDX) && (r_cnt == DWELL_LAST);
  assign frame_o  = w_frame;
  assign in_ready = ~r_pendFull;
  assign w_load   = in_valid && in_ready;
  assign an_o     = r_an;
  assign seg_o    = r_seg;

  // Pins are registered from the next state so they line up with the state of the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_BLANK;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_an    <= 8'hFF;
      r_seg   <= 8'hFF;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
      r_cnt   <= w_cntNext;
      r_an    <= w_anNext;
      r_seg   <= w_segNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_cntNext   = r_cnt + 1'b1;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_stateNext = ST_SHOW;
          w_cntNext   = '0;
        end
      end
      ST_SHOW: begin
        if (r_cnt == DWELL_LAST) begin
          w_stateNext = ST_BLANK;
          w_cntNext   = '0;
          w_idxNext   = r_idx + 1'b1;
        end
      end
      default: begin
        w_stateNext = ST_BLANK;
        w_cntNext   = '0;
      end
    endcase
  end

  // Pending can only be full at the boundary when in_ready is low, so swap and load never collide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend     <= '0;
      r_act      <= '0;
      r_pendFull <= 1'b0;
    end else begin
      if (w_frame && r_pendFull) begin
        r_act      <= r_pend;
        r_pendFull <= 1'b0;
      end
      if (w_load) begin
        r_pend     <= '{data: in_data, dp: in_dp, dp_en: in_dp_en, lzs: in_lzs};
        r_pendFull <= 1'b1;
      end
    end
  end

  assign w_nibble = r_act.data[w_idxNext*NIBBLE_W +: NIBBLE_W];
  assign w_highNz = highestNonzero(r_act.data);

  seg_font u_font (
    .i_nibble (w_nibble),
    .o_seg    (w_fontSeg)
  );

  always_comb begin
    w_suppress = r_act.lzs && (w_idxNext > w_highNz) &&
                 !(r_act.dp_en && (w_idxNext <= r_act.dp));
    w_anNext   = 8'hFF;
    w_segNext  = 8'hFF;
    if (en && (w_stateNext == ST_SHOW)) begin
      w_anNext = ~(8'h01 << w_idxNext);
      if (!w_suppress) begin
        w_segNext = w_fontSeg;
        if (r_act.dp_en && (w_idxNext == r_act.dp)) w_segNext[7] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (DWELL=4, BLANK=2, 48-cycle frame):
// directed loads push per-cycle expectations, a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

  localparam int FRAME = 48;
  localparam int B0    = 3;
  localparam int B1    = B0 + 403;

  logic        clk;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_dp;
  logic        in_dp_en;
  logic        in_lzs;
  logic [7:0]  seg_o;
  logic [7:0]  an_o;
  logic        frame_o;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] an;
    logic [7:0] seg;
    logic       bitv;
    string      name;
  } expT;

  expT q[$];
  int  cyc        = 0;
  int  compared   = 0;
  int  mismatched = 0;

  seg_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dp    (in_dp),
    .in_dp_en (in_dp_en),
    .in_lzs   (in_lzs),
    .seg_o    (seg_o),
    .an_o     (an_o),
    .frame_o  (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int L(input int l);
    return B0 + l;
  endfunction

  function automatic int P(input int l);
    return B1 + l;
  endfunction

  function automatic void pushExp(input int c, input int kind, input logic [7:0] an,
                                  input logic [7:0] seg, input logic b, input string nm);
    expT e;
    int  i;
    e.cyc = c; e.kind = kind; e.an = an; e.seg = seg; e.bitv = b; e.name = nm;
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, e);
  endfunction

  function automatic void expPins(input int c, input logic [7:0] an, input logic [7:0] seg, input string nm);
    pushExp(c, 0, an, seg, 1'b0, nm);
  endfunction

  function automatic void expFrame(input int c, input logic b, input string nm);
    pushExp(c, 1, 8'h00, 8'h00, b, nm);
  endfunction

  function automatic void expReady(input int c, input logic b, input string nm);
    pushExp(c, 2, 8'h00, 8'h00, b, nm);
  endfunction

  task automatic checkOutput(input expT e);
    compared++;
    case (e.kind)
      0: if (an_o !== e.an || seg_o !== e.seg) begin
           mismatched++;
           $display("[TB] FAIL %s @cyc %0d: got an=%02h seg=%02h, want an=%02h seg=%02h",
                    e.name, e.cyc, an_o, seg_o, e.an, e.seg);
         end
      1: if (frame_o !== e.bitv) begin
           mismatched++;
           $display("[TB] FAIL %s @cyc %0d: got frame_o=%b, want %b", e.name, e.cyc, frame_o, e.bitv);
         end
      default: if (in_ready !== e.bitv) begin
           mismatched++;
           $display("[TB] FAIL %s @cyc %0d: got in_ready=%b, want %b", e.name, e.cyc, in_ready, e.bitv);
         end
    endcase
  endtask

  // Monitor: compares every expectation due this cycle, flags any it has already passed
  always @(negedge clk) begin
    expT e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL %s @cyc %0d: expectation not reached in order, want checked at %0d",
                 e.name, cyc, e.cyc);
      end else begin
        checkOutput(e);
      end
    end
    cyc++;
  end

  task automatic gotoCycle(input int g);
    while (cyc < g) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int g, input logic v, input logic [31:0] d,
                               input logic [2:0] dp, input logic dpEn, input logic lzs);
    gotoCycle(g);
    in_valid = v;
    in_data  = d;
    in_dp    = dp;
    in_dp_en = dpEn;
    in_lzs   = lzs;
  endtask

  initial begin
    logic [7:0] anv;
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0;
    in_dp = '0; in_dp_en = 1'b0; in_lzs = 1'b0;

    for (int g = 0; g < B0; g++) begin
      expPins(g, 8'hFF, 8'hFF, "reset_pins");
      expFrame(g, 1'b0, "reset_frame");
      expReady(g, 1'b1, "reset_ready");
    end
    for (int l = 0; l <= 402; l++) expFrame(L(l), (l % FRAME) == FRAME - 1, "frame_pulse");

    // Power-up scan of an all-zero display
    expPins(L(0), 8'hFF, 8'hFF, "blank_c0");
    expPins(L(1), 8'hFF, 8'hFF, "blank_c1");
    for (int l = 2; l <= 5; l++) expPins(L(l), 8'hFE, 8'hC0, "dig0_zero");
    expPins(L(6), 8'hFF, 8'hFF, "blank_dig1");
    for (int l = 8; l <= 11; l++) expPins(L(l), 8'hFD, 8'hC0, "dig1_zero");
    expPins(L(45), 8'h7F, 8'hC0, "f0_dig7_old");
    gotoCycle(B0);
    rst = 1'b1;

    // 0x16, dp on digit 1, zero blanking
    expReady(L(20), 1'b1, "lzs_ready_before");
    expReady(L(21), 1'b0, "lzs_ready_drop");
    expReady(L(47), 1'b0, "lzs_ready_at_boundary");
    expReady(L(48), 1'b1, "lzs_ready_after_swap");
    expPins(L(48), 8'hFF, 8'hFF, "f1_blank");
    expPins(L(50), 8'hFE, 8'h82, "f1_dig0_first");
    expPins(L(53), 8'hFE, 8'h82, "f1_dig0_last");
    expPins(L(56), 8'hFD, 8'h79, "f1_dig1_dp");
    for (int k = 2; k < 8; k++) begin
      anv = ~(8'h01 << k);
      expPins(L(48 + 6*k + 3), anv, 8'hFF, "f1_lzs_blank");
    end
    applyStimulus(L(20), 1'b1, 32'h0000_0016, 3'd1, 1'b1, 1'b1);
    applyStimulus(L(21), 1'b0, 32'h0000_0016, 3'd1, 1'b1, 1'b1);

    // Back-to-back loads: second waits for the buffer to drain
    expPins(L(99), 8'hFE, 8'h82, "f2_dig0_keep");
    expReady(L(100), 1'b1, "bb_first_ready");
    expReady(L(101), 1'b0, "bb_second_held");
    expReady(L(120), 1'b0, "bb_still_held");
    expReady(L(143), 1'b0, "bb_boundary_held");
    expReady(L(144), 1'b1, "bb_second_accept");
    expReady(L(145), 1'b0, "bb_second_pending");
    expPins(L(147), 8'hFE, 8'hF9, "f3_dig0_one");
    expPins(L(153), 8'hFD, 8'hC0, "f3_dig1_zero");
    expPins(L(189), 8'h7F, 8'hC0, "f3_dig7_zero");
    expPins(L(195), 8'hFE, 8'hA4, "f4_dig0_two");
    applyStimulus(L(100), 1'b1, 32'h0000_0001, 3'd0, 1'b0, 1'b0);
    applyStimulus(L(101), 1'b1, 32'h0000_0002, 3'd0, 1'b0, 1'b0);
    applyStimulus(L(145), 1'b0, 32'h0000_0002, 3'd0, 1'b0, 1'b0);

    // Load landing on the boundary cycle is deferred one frame
    expReady(L(239), 1'b1, "bnd_ready");
    expReady(L(240), 1'b0, "bnd_pending");
    expReady(L(287), 1'b0, "bnd_pending_next");
    expReady(L(288), 1'b1, "bnd_swapped");
    expPins(L(243), 8'hFE, 8'hA4, "f5_dig0_old");
    expPins(L(291), 8'hFE, 8'h8E, "f6_dig0_F");
    expPins(L(297), 8'hFD, 8'hC0, "f6_dig1_zero");
    applyStimulus(L(239), 1'b1, 32'h0000_000F, 3'd0, 1'b0, 1'b0);
    applyStimulus(L(240), 1'b0, 32'h0000_000F, 3'd0, 1'b0, 1'b0);

    // Display disabled for the whole of frame 7
    expPins(L(336), 8'hFF, 8'hFF, "en_off_start");
    for (int k = 0; k < 8; k++) expPins(L(336 + 6*k + 3), 8'hFF, 8'hFF, "en_off_show");
    expPins(L(383), 8'hFF, 8'hFF, "en_off_end");
    expPins(L(387), 8'hFE, 8'h8E, "en_back_on");
    gotoCycle(L(334));
    en = 1'b0;
    gotoCycle(L(384));
    en = 1'b1;

    // Reset mid-SHOW with a load still pending
    expReady(L(390), 1'b1, "rst_load_ready");
    expReady(L(391), 1'b0, "rst_load_pending");
    expPins(L(399), 8'hFB, 8'hC0, "pre_rst_dig2");
    for (int l = 400; l <= 402; l++) expPins(L(l), 8'hFF, 8'hFF, "rst_pins_async");
    expReady(L(400), 1'b1, "rst_ready");
    expPins(P(0), 8'hFF, 8'hFF, "post_rst_blank0");
    expPins(P(1), 8'hFF, 8'hFF, "post_rst_blank1");
    for (int k = 0; k < 8; k++) begin
      anv = ~(8'h01 << k);
      expPins(P(6*k + 3), anv, 8'hC0, "post_rst_zero");
    end
    expPins(P(51), 8'hFE, 8'hC0, "post_rst_f1_dig0");
    expReady(P(0), 1'b1, "post_rst_ready");
    expReady(P(10), 1'b1, "post_rst_no_pend");
    for (int l = 0; l < 2*FRAME; l++) expFrame(P(l), (l % FRAME) == FRAME - 1, "post_rst_frame");
    applyStimulus(L(390), 1'b1, 32'h1234_5678, 3'd4, 1'b1, 1'b1);
    applyStimulus(L(391), 1'b0, 32'h1234_5678, 3'd4, 1'b1, 1'b1);
    gotoCycle(L(400));
    rst = 1'b0;
    gotoCycle(B1);
    rst = 1'b1;

    gotoCycle(P(2*FRAME + 4));
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
